// File: rtl/regfile_spi_dump.sv
// regfile_spi_dump
//   SPI-master (mode 0, MSB first) that walks a contiguous, possibly
//   wrapping, range of register-file entries through the file's second
//   read port and shifts each word out on mosi. All words of one dump go
//   out inside a single ss_n frame.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous, active-high
//   start      one-cycle dump request, accepted only when idle
//   first_sel  first register index (sampled with start)
//   last_sel   last register index, inclusive (sampled with start)
//   r_data     combinational read data from the register file
//   r_sel      registered read select to the register file
//   sclk       SPI clock, idle low
//   mosi       serial data out
//   ss_n       slave select, active low
//   busy       high while a dump is in progress
//   done       one-cycle pulse when the last word has finished
module regfile_spi_dump #(
  parameter int NUM_BITS     = 17,
  parameter int NUM_SEL_BITS = 4,
  parameter int CLK_DIV      = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic        [NUM_SEL_BITS-1:0] first_sel,
  input  logic        [NUM_SEL_BITS-1:0] last_sel,
  input  logic signed [NUM_BITS-1:0]     r_data,
  output logic        [NUM_SEL_BITS-1:0] r_sel,
  output logic                           sclk,
  output logic                           mosi,
  output logic                           ss_n,
  output logic                           busy,
  output logic                           done
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_W = $clog2(NUM_BITS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  generate
    if (CLK_DIV < 1) begin : g_bad_div
      $error("regfile_spi_dump: CLK_DIV must be 1 or more");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_FINISH
  } state_t;

  state_t                  r_state,   w_state;
  logic [NUM_SEL_BITS-1:0] r_cur,     w_cur;
  logic [NUM_SEL_BITS-1:0] r_last,    w_last;
  logic [NUM_BITS-1:0]     r_shreg,   w_shreg;
  logic [CNT_W-1:0]        r_bit_cnt, w_bit_cnt;
  logic [DIV_W-1:0]        r_div,     w_div;
  logic                    r_sclk,    w_sclk;
  logic                    r_ss_n,    w_ss_n;
  logic                    r_busy,    w_busy;
  logic                    r_done,    w_done;
  logic                    w_half_end;

  // Last clk cycle of the current sclk half-period.
  assign w_half_end = (r_div == DIV_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cur     <= '0;
      r_last    <= '0;
      r_shreg   <= '0;
      r_bit_cnt <= '0;
      r_div     <= '0;
      r_sclk    <= 1'b0;
      r_ss_n    <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_cur     <= w_cur;
      r_last    <= w_last;
      r_shreg   <= w_shreg;
      r_bit_cnt <= w_bit_cnt;
      r_div     <= w_div;
      r_sclk    <= w_sclk;
      r_ss_n    <= w_ss_n;
      r_busy    <= w_busy;
      r_done    <= w_done;
    end
  end

  always_comb begin
    w_state   = r_state;
    w_cur     = r_cur;
    w_last    = r_last;
    w_shreg   = r_shreg;
    w_bit_cnt = r_bit_cnt;
    w_div     = r_div;
    w_sclk    = r_sclk;
    w_ss_n    = r_ss_n;
    w_busy    = r_busy;
    w_done    = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state = S_LOAD;
          w_cur   = first_sel;
          w_last  = last_sel;
          w_ss_n  = 1'b0;
          w_busy  = 1'b1;
        end
      end

      // r_sel has been stable since the previous edge, so r_data is
      // valid now; this cycle is the word's snapshot point.
      S_LOAD: begin
        w_shreg   = r_data;
        w_bit_cnt = CNT_W'(NUM_BITS);
        w_div     = '0;
        w_sclk    = 1'b0;
        w_state   = S_SHIFT;
      end

      S_SHIFT: begin
        if (!w_half_end) begin
          w_div = r_div + 1'b1;
        end else begin
          w_div = '0;
          if (!r_sclk) begin
            w_sclk = 1'b1;
          end else begin
            // Falling edge: next bit onto mosi while sclk goes low.
            // Zeros shift in, so after a full word mosi rests at 0
            // through LOAD and FINISH without a separate mosi flop.
            w_sclk    = 1'b0;
            w_shreg   = {r_shreg[NUM_BITS-2:0], 1'b0};
            w_bit_cnt = r_bit_cnt - 1'b1;
            if (r_bit_cnt == CNT_W'(1)) begin
              if (r_cur == r_last) begin
                w_state = S_FINISH;
                w_ss_n  = 1'b1;
                w_busy  = 1'b0;
                w_done  = 1'b1;
              end else begin
                // Natural wrap past the top register.
                w_cur   = r_cur + 1'b1;
                w_state = S_LOAD;
              end
            end
          end
        end
      end

      // start is deliberately not looked at here.
      S_FINISH: w_state = S_IDLE;

      default: w_state = S_IDLE;
    endcase
  end

  assign r_sel = r_cur;
  assign sclk  = r_sclk;
  assign mosi  = r_shreg[NUM_BITS-1];
  assign ss_n  = r_ss_n;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule

// File: tb/tb_regfile_spi_dump.sv
// tb_regfile_spi_dump
//   Two instances (CLK_DIV=4 and CLK_DIV=1) share one behavioural register
//   file. A monitor deserialises mosi on sclk rising edges; a dump-level
//   model derives the index walk, snapshot points and timing from the
//   word-span rule and compares against what the monitor collected.
module tb_regfile_spi_dump;
  localparam int NB  = 17;
  localparam int NS  = 4;
  localparam int NR  = 16;
  localparam int WSA = 1 + 2*4*NB;
  localparam int WSB = 1 + 2*1*NB;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [NB-1:0] regs [NR];

  logic          a_start, b_start;
  logic [NS-1:0] a_first, a_last, b_first, b_last;
  logic [NS-1:0] a_rsel, b_rsel;
  logic [NB-1:0] a_rdata, b_rdata;
  logic          a_sclk, a_mosi, a_ssn, a_busy, a_done;
  logic          b_sclk, b_mosi, b_ssn, b_busy, b_done;

  assign a_rdata = regs[a_rsel];
  assign b_rdata = regs[b_rsel];

  regfile_spi_dump #(.NUM_BITS(NB), .NUM_SEL_BITS(NS), .CLK_DIV(4)) u_a (
    .clk(clk), .reset(reset), .start(a_start), .first_sel(a_first),
    .last_sel(a_last), .r_data(a_rdata), .r_sel(a_rsel), .sclk(a_sclk),
    .mosi(a_mosi), .ss_n(a_ssn), .busy(a_busy), .done(a_done));

  regfile_spi_dump #(.NUM_BITS(NB), .NUM_SEL_BITS(NS), .CLK_DIV(1)) u_b (
    .clk(clk), .reset(reset), .start(b_start), .first_sel(b_first),
    .last_sel(b_last), .r_data(b_rdata), .r_sel(b_rsel), .sclk(b_sclk),
    .mosi(b_mosi), .ss_n(b_ssn), .busy(b_busy), .done(b_done));

  // Monitored instance select.
  logic          sel_b = 1'b0;
  logic          m_sclk, m_mosi, m_ssn, m_busy, m_done;
  logic [NS-1:0] m_rsel;
  assign m_sclk = sel_b ? b_sclk : a_sclk;
  assign m_mosi = sel_b ? b_mosi : a_mosi;
  assign m_ssn  = sel_b ? b_ssn  : a_ssn;
  assign m_busy = sel_b ? b_busy : a_busy;
  assign m_done = sel_b ? b_done : a_done;
  assign m_rsel = sel_b ? b_rsel : a_rsel;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Monitor: sampled 1 time unit after each rising clk edge.
  int            clr_req = 0;
  int            clr_seen = 0;
  int            rises, nacc, mode0_err, done_cnt;
  logic [NB-1:0] acc;
  logic [NB-1:0] got [$];
  int            sel_log [$];
  logic          p_sclk = 1'b0, p_mosi = 1'b0, p_busy = 1'b0;
  logic [NS-1:0] p_rsel = '0;

  always @(posedge clk) begin
    #1;
    if (clr_req != clr_seen) begin
      clr_seen = clr_req;
      rises = 0; nacc = 0; acc = '0; mode0_err = 0; done_cnt = 0;
      got.delete();
      sel_log.delete();
    end else begin
      if (m_sclk && !p_sclk) begin
        rises++;
        acc = {acc[NB-2:0], m_mosi};
        nacc++;
        if (nacc == NB) begin
          got.push_back(acc);
          nacc = 0;
        end
      end
      // Mode 0: mosi may not move while sclk is (or just went) high.
      if (m_sclk && (m_mosi !== p_mosi)) mode0_err++;
      if (m_busy && (!p_busy || m_rsel != p_rsel)) sel_log.push_back(int'(m_rsel));
      if (m_done) done_cnt++;
    end
    p_sclk = m_sclk; p_mosi = m_mosi; p_busy = m_busy; p_rsel = m_rsel;
  end

  task automatic drv_start(input bit use_b, input logic v, input int f, input int l);
    if (use_b) begin
      b_start = v; b_first = NS'(f); b_last = NS'(l);
    end else begin
      a_start = v; a_first = NS'(f); a_last = NS'(l);
    end
  endtask

  // One dump: expected words are snapshotted from regs at each word's LOAD
  // cycle, c = k*word_span after the start edge. Optional coherency mode
  // rewrites regs 8/9 and pulses a stray start during word 0. A start is
  // also pulsed in the done cycle and must be ignored.
  task automatic run_dump(input int first, input int last, input bit use_b, input bit coh);
    int            K, ws, dcyc;
    logic [NB-1:0] exp_w [$];
    int            exp_sel [$];
    K  = ((last - first) & (NR-1)) + 1;
    ws = use_b ? WSB : WSA;
    for (int k = 0; k < K; k++) exp_sel.push_back((first + k) % NR);
    sel_b = use_b;
    @(negedge clk);
    clr_req++;
    @(negedge clk);
    drv_start(use_b, 1'b1, first, last);
    @(negedge clk);
    drv_start(use_b, 1'b0, first, last);
    dcyc = -1;
    for (int c = 0; c < K*ws + 40; c++) begin
      if (c % ws == 0 && c / ws < K) exp_w.push_back(regs[exp_sel[c / ws]]);
      if (coh && c == 60) begin
        regs[8] = NB'($urandom);
        regs[9] = NB'($urandom);
        drv_start(use_b, 1'b1, 0, 15);
      end
      if (coh && c == 61) drv_start(use_b, 1'b0, first, last);
      if (dcyc < 0 && m_done) begin
        dcyc = c;
        drv_start(use_b, 1'b1, first, last);
      end else if (dcyc >= 0 && c == dcyc + 1) begin
        drv_start(use_b, 1'b0, first, last);
      end
      if (dcyc >= 0 && c == dcyc + 4) break;
      @(negedge clk);
    end
    drv_start(use_b, 1'b0, first, last);
    chk("span", 32'(dcyc), 32'(K*ws));
    chk("rises", 32'(rises), 32'(K*NB));
    chk("nwords", 32'(got.size()), 32'(K));
    for (int k = 0; k < K && k < got.size(); k++) chk("word", 32'(got[k]), 32'(exp_w[k]));
    chk("nsel", 32'(sel_log.size()), 32'(K));
    for (int k = 0; k < K && k < sel_log.size(); k++) chk("rsel", 32'(sel_log[k]), 32'(exp_sel[k]));
    chk("done_cnt", 32'(done_cnt), 32'd1);
    chk("mode0", 32'(mode0_err), 32'd0);
    chk("idle_after", 32'({m_busy, m_ssn, m_sclk, m_mosi}), 32'b0100);
  endtask

  initial begin
    a_start = 1'b0; a_first = '0; a_last = '0;
    b_start = 1'b0; b_first = '0; b_last = '0;
    for (int i = 0; i < NR; i++) regs[i] = NB'($urandom);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_a", 32'({a_rsel, a_sclk, a_mosi, a_ssn, a_busy, a_done}), 32'b0000_0_0_1_0_0);
    chk("rst_b", 32'({b_rsel, b_sclk, b_mosi, b_ssn, b_busy, b_done}), 32'b0000_0_0_1_0_0);
    reset = 1'b0;

    regs[3] = 17'h1A5A5;
    run_dump(3, 3, 1'b0, 1'b0);

    regs[5] = 17'h00001; regs[6] = 17'h1FFFF; regs[7] = 17'h10000;
    run_dump(5, 7, 1'b0, 1'b0);

    run_dump(14, 1, 1'b0, 1'b0);

    run_dump(8, 9, 1'b0, 1'b1);

    regs[3] = NB'($urandom);
    run_dump(3, 3, 1'b1, 1'b0);

    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < NR; i++) regs[i] = NB'($urandom);
      run_dump(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), (t % 3 == 2), 1'b0);
    end

    // Abort mid-dump with an asynchronous reset between clock edges.
    sel_b = 1'b0;
    @(negedge clk);
    drv_start(1'b0, 1'b1, 0, 15);
    @(negedge clk);
    drv_start(1'b0, 1'b0, 0, 15);
    repeat ($urandom_range(2, 2000)) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("rst_mid", 32'({a_rsel, a_ssn, a_sclk, a_mosi, a_busy, a_done}), 32'b0000_1_0_0_0_0);
    @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    chk("rst_idle", 32'({a_ssn, a_busy, a_sclk, a_done}), 32'b1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
